// File: rtl/check_sequencer.sv
// Sequences one check run: clears the checker, pops words from the source FIFO,
// strobes compare/advance for each word, then captures the checker's error count.
module check_sequencer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          word_count,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 reset_pattern,
  output logic                 reset_err_counter,
  output logic                 enable_pattern,
  output logic                 check_for_errors,
  input  logic [31:0]          error_count_in,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic                 aborted,
  output logic [31:0]          words_checked,
  output logic [31:0]          final_errors
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    SETTLE,
    FINISH
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [31:0]          word_count_q;
  logic [31:0]          issued;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] stall_cnt;
  logic                 check_q;
  logic                 pop;
  logic                 final_pop;
  logic                 stall_expired;
  logic                 set_timed_out;
  logic                 set_aborted;

  // The pop is qualified by the live empty flag so the FIFO is never over-read;
  // an abort in the same cycle already blocks the pop.
  assign pop           = (state == RUN) && !fifo_empty && !abort && (issued < word_count_q);
  assign final_pop     = pop && (issued == word_count_q - 32'd1);
  assign stall_expired = (state == RUN) && !pop && (timeout_q != '0) &&
                         (stall_cnt <= TIMEOUT_W'(1));

  always_comb begin
    state_next    = state;
    set_timed_out = 1'b0;
    set_aborted   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        if (abort) begin
          set_aborted = 1'b1;
          state_next  = SETTLE;
        end else if (word_count_q == 32'd0) begin
          state_next = SETTLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          set_aborted = 1'b1;
          state_next  = SETTLE;
        end else if (final_pop) begin
          state_next = DRAIN;
        end else if (stall_expired) begin
          set_timed_out = 1'b1;
          state_next    = SETTLE;
        end
      end
      DRAIN: begin
        if (abort) set_aborted = 1'b1;
        state_next = SETTLE;
      end
      SETTLE:  state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run parameters and status flags are refreshed on the accepted start, so
  // they already read as cleared while the checker is being reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      word_count_q  <= '0;
      timeout_q     <= '0;
      issued        <= '0;
      stall_cnt     <= '0;
      check_q       <= 1'b0;
      words_checked <= '0;
      final_errors  <= '0;
      timed_out     <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state   <= state_next;
      check_q <= pop;

      if (state == IDLE && start) begin
        word_count_q  <= word_count;
        timeout_q     <= timeout_cycles;
        issued        <= '0;
        words_checked <= '0;
        timed_out     <= 1'b0;
        aborted       <= 1'b0;
      end else begin
        if (pop) issued <= issued + 32'd1;
        if (check_q) words_checked <= words_checked + 32'd1;
        if (set_timed_out) timed_out <= 1'b1;
        if (set_aborted) aborted <= 1'b1;
      end

      if ((state == CLEAR && state_next == RUN) || pop) begin
        stall_cnt <= timeout_q;
      end else if (state == RUN && stall_cnt != '0) begin
        stall_cnt <= stall_cnt - TIMEOUT_W'(1);
      end

      if (state == FINISH) final_errors <= error_count_in;
    end
  end

  assign fifo_rd_en        = pop;
  assign reset_pattern     = (state == CLEAR);
  assign reset_err_counter = (state == CLEAR);
  assign check_for_errors  = check_q;
  assign enable_pattern    = check_q;
  assign busy              = (state != IDLE);
  assign done              = (state == FINISH);

endmodule

// File: tb/tb_check_sequencer.sv
// Randomized scoreboard bench for check_sequencer: a cycle-indexed reference model
// predicts each run's outcome, and a monitor checks it when done pulses.
module tb_check_sequencer;

  localparam int TW      = 16;
  localparam int PAT_LEN = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [31:0]   word_count;
  logic [TW-1:0] timeout_cycles;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          reset_pattern;
  logic          reset_err_counter;
  logic          enable_pattern;
  logic          check_for_errors;
  logic [31:0]   error_count_in;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic          aborted;
  logic [31:0]   words_checked;
  logic [31:0]   final_errors;

  check_sequencer #(.TIMEOUT_W(TW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .word_count        (word_count),
    .timeout_cycles    (timeout_cycles),
    .fifo_empty        (fifo_empty),
    .fifo_rd_en        (fifo_rd_en),
    .reset_pattern     (reset_pattern),
    .reset_err_counter (reset_err_counter),
    .enable_pattern    (enable_pattern),
    .check_for_errors  (check_for_errors),
    .error_count_in    (error_count_in),
    .busy              (busy),
    .done              (done),
    .timed_out         (timed_out),
    .aborted           (aborted),
    .words_checked     (words_checked),
    .final_errors      (final_errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    int doneCyc;
    int pops;
    int errs;
    bit tmo;
    bit abt;
  } exp_t;

  exp_t  expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  int    cyc = 0;
  bit    emptyPat[PAT_LEN];
  bit    badWord[PAT_LEN];
  int    abortAt;
  int    checkerIdx;
  logic [31:0] checkerCnt;

  // Checker stand-in: compares the current word, then the generator advances.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || reset_pattern) checkerIdx <= 0;
    else if (enable_pattern) checkerIdx <= checkerIdx + 1;
    if (reset || reset_err_counter) checkerCnt <= '0;
    else if (check_for_errors && checkerIdx < PAT_LEN && badWord[checkerIdx])
      checkerCnt <= checkerCnt + 32'd1;
  end
  assign error_count_in = checkerCnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit emptyAt(input int k);
    return (k >= 0 && k < PAT_LEN) ? emptyPat[k] : 1'b0;
  endfunction

  // Cycle k counts from the start cycle (k=0); k=1 clears, pops may begin at k=2.
  function automatic exp_t predict(input int wc, input int tmo, input int startCyc);
    exp_t e;
    int   k;
    int   idle;
    int   endK;
    e.pops = 0;
    e.errs = 0;
    e.tmo  = 1'b0;
    e.abt  = 1'b0;
    endK   = 0;
    if (abortAt == 1) begin
      e.abt = 1'b1;
      endK  = 1;
    end else if (wc == 0) begin
      endK = 1;
    end else begin
      k    = 2;
      idle = 0;
      while (endK == 0) begin
        if (k == abortAt) begin
          e.abt = 1'b1;
          endK  = k;
        end else if (!emptyAt(k)) begin
          e.pops++;
          idle = 0;
          if (e.pops == wc) begin
            endK = k + 1;
            if (abortAt == k + 1) e.abt = 1'b1;
          end
        end else begin
          idle++;
          if (tmo != 0 && idle >= tmo) begin
            e.tmo = 1'b1;
            endK  = k;
          end
        end
        k++;
      end
    end
    for (int i = 0; i < e.pops; i++) if (badWord[i]) e.errs++;
    e.doneCyc = startCyc + endK + 2;
    return e;
  endfunction

  task automatic applyStimulus(input int wc, input int tmo, input bit junk);
    exp_t e;
    int   doneK;
    @(posedge clk); #1;
    start          = 1'b1;
    abort          = 1'b0;
    word_count     = wc;
    timeout_cycles = TW'(tmo);
    fifo_empty     = emptyAt(0);
    e = predict(wc, tmo, cyc);
    expQ.push_back(e);
    doneK = e.doneCyc - cyc;
    for (int k = 1; k <= doneK + 1; k++) begin
      @(posedge clk); #1;
      start          = junk && (k <= doneK) && ($urandom_range(0, 3) == 0);
      word_count     = $urandom;
      timeout_cycles = TW'($urandom);
      fifo_empty     = emptyAt(k);
      abort          = (k == abortAt) ||
                       (junk && k >= doneK - 1 && k <= doneK && $urandom_range(0, 1) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_seen", expQ.size(), 0);
    expQ.delete();
  endtask

  int  popCount = 0;
  bit  prevPop = 1'b0;
  bit  prevReset = 1'b1;
  bit  feCheck = 1'b0;
  int  feExp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (feCheck) begin
      checkOutput("final_errors", final_errors, feExp);
      feCheck = 1'b0;
    end
    if (start && !busy && !reset) popCount = 0;
    if (fifo_rd_en) popCount++;
    if (!reset) begin
      checkOutput("pop_on_empty", fifo_rd_en & fifo_empty, 1'b0);
      if (!prevReset) begin
        checkOutput("check_follows_pop", check_for_errors, prevPop);
        checkOutput("enable_with_check", enable_pattern, check_for_errors);
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("done_expected", expQ.size(), 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_cycle", cyc, e.doneCyc);
          checkOutput("words_checked", words_checked, e.pops);
          checkOutput("pop_count", popCount, e.pops);
          checkOutput("timed_out", timed_out, e.tmo);
          checkOutput("aborted", aborted, e.abt);
          checkOutput("busy_at_done", busy, 1'b1);
          feCheck = 1'b1;
          feExp   = e.errs;
        end
      end
    end
    prevPop   = fifo_rd_en && !reset;
    prevReset = reset;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    fifo_empty     = 1'b1;
    word_count     = '0;
    timeout_cycles = '0;
    abortAt        = -1;
    for (int i = 0; i < PAT_LEN; i++) begin
      emptyPat[i] = 1'b0;
      badWord[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_timed_out", timed_out, 1'b0);
    checkOutput("rst_aborted", aborted, 1'b0);
    checkOutput("rst_words_checked", words_checked, 32'd0);
    checkOutput("rst_final_errors", final_errors, 32'd0);
    checkOutput("rst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("rst_check", check_for_errors, 1'b0);
    checkOutput("rst_reset_pattern", reset_pattern, 1'b0);
    reset = 1'b0;

    // Eight words, FIFO always ready, no errors: done twelve cycles after start.
    applyStimulus(8, 0, 1'b0);

    // Four words with the FIFO toggling empty, two bad words.
    for (int i = 0; i < PAT_LEN; i++) emptyPat[i] = (i % 2 == 1);
    badWord[1] = 1'b1;
    badWord[3] = 1'b1;
    applyStimulus(4, 0, 1'b0);

    // Zero-length run.
    for (int i = 0; i < PAT_LEN; i++) begin
      emptyPat[i] = 1'b0;
      badWord[i]  = 1'b0;
    end
    applyStimulus(0, 0, 1'b0);

    // Stall timeout after three pops.
    for (int i = 0; i < PAT_LEN; i++) emptyPat[i] = (i >= 5);
    applyStimulus(10, 5, 1'b0);

    // Abort two cycles after the first pop.
    for (int i = 0; i < PAT_LEN; i++) emptyPat[i] = 1'b0;
    abortAt = 4;
    applyStimulus(100, 0, 1'b0);
    abortAt = -1;

    // Reset with a simultaneous start in the middle of a run.
    @(posedge clk); #1;
    start      = 1'b1;
    word_count = 32'd20;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("mid_rst_check", check_for_errors, 1'b0);
    checkOutput("mid_rst_words_checked", words_checked, 32'd0);
    checkOutput("mid_rst_final_errors", final_errors, 32'd0);
    checkOutput("mid_rst_timed_out", timed_out, 1'b0);
    checkOutput("mid_rst_aborted", aborted, 1'b0);
    repeat (4) @(posedge clk);

    // Randomized runs with stray start/abort pulses in states that must ignore them.
    for (int r = 0; r < 30; r++) begin
      int wc;
      int tmo;
      int emptyPct;
      wc       = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      tmo      = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
      emptyPct = $urandom_range(0, 60);
      for (int i = 0; i < PAT_LEN; i++) begin
        emptyPat[i] = ($urandom_range(0, 99) < emptyPct);
        badWord[i]  = ($urandom_range(0, 3) == 0);
      end
      abortAt = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 50) : -1;
      applyStimulus(wc, tmo, 1'b1);
    end
    abortAt = -1;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
